// File: rtl/stereo_pattern_tx.sv
// stereo_pattern_tx: AXI4-Stream synthetic stereo frame generator.
// Column-interleaved L/R texture with a known disparity for pipeline bring-up.
module stereo_pattern_tx #(
    parameter int WIDTH                 = 3840,
    parameter int HEIGHT                = 2160,
    parameter int MAX_SAMPLES_PER_CLOCK = 4,
    parameter int AXIS_TDATA_WIDTH      = 32,
    parameter int H_BLANK               = 8,
    parameter int V_BLANK               = 64
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enable,
    input  logic [7:0]                    disp_shift,
    output logic [3*AXIS_TDATA_WIDTH-1:0] m_axis_img_tdata,
    output logic                          m_axis_img_tuser,
    output logic                          m_axis_img_tlast,
    output logic                          m_axis_img_tvalid,
    input  logic                          m_axis_img_tready,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt
);

    localparam int MSPC  = MAX_SAMPLES_PER_CLOCK;
    localparam int TDW   = 3 * AXIS_TDATA_WIDTH;
    localparam int BEATS = WIDTH / MSPC;
    localparam int BXW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GMAX  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int GW    = (GMAX > 1) ? $clog2(GMAX) : 1;

    localparam logic [BXW-1:0] BX_LAST = BXW'(BEATS - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [GW-1:0]  H_LAST  = GW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [GW-1:0]  V_LAST  = GW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HGAP,
        S_VGAP
    } state_t;

    state_t           state_q, state_d;
    logic [BXW-1:0]   bx_q, bx_d;
    logic [YW-1:0]    y_q, y_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [7:0]       d_q, d_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [TDW-1:0]   tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tuser_q, tuser_d;
    logic             tlast_q, tlast_d;
    logic             accept;

    // Pixels of one beat: even x samples the left view, odd x the right view shifted by d.
    function automatic logic [TDW-1:0] beat_pixels(
        input logic [BXW-1:0] bx,
        input logic [YW-1:0]  y,
        input logic [7:0]     d
    );
        logic [TDW-1:0] data;
        logic [7:0]     cb, yb, hc, hy, v;
        int             x;
        data = '0;
        yb   = 8'(y);
        hy   = yb * 8'd101;
        for (int k = 0; k < MSPC; k++) begin
            x  = int'(bx) * MSPC + k;
            cb = 8'(x >> 1);
            if (x[0]) begin
                cb = cb + d;
            end
            hc = cb * 8'd37;
            v  = hc ^ hy;
            data[24*k +: 24] = {v, v, v};
        end
        return data;
    endfunction

    assign accept = tvalid_q & m_axis_img_tready;

    // Next-state, beat counters, disparity latch and registered AXIS outputs.
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        y_d     = y_q;
        gap_d   = gap_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ACTIVE;
                    bx_d    = '0;
                    y_d     = '0;
                    d_d     = disp_shift;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (bx_q != BX_LAST) begin
                        bx_d = bx_q + 1'b1;
                    end else begin
                        bx_d  = '0;
                        gap_d = '0;
                        if (y_q != Y_LAST) begin
                            y_d = y_q + 1'b1;
                            if (H_BLANK > 0) begin
                                state_d = S_HGAP;
                            end
                        end else begin
                            y_d   = '0;
                            cnt_d = cnt_q + 16'd1;
                            if (V_BLANK > 0) begin
                                state_d = S_VGAP;
                            end else if (enable) begin
                                d_d = disp_shift;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
            end
            S_HGAP: begin
                if (gap_q == H_LAST) begin
                    state_d = S_ACTIVE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_VGAP: begin
                if (gap_q == V_LAST) begin
                    if (enable) begin
                        state_d = S_ACTIVE;
                        d_d     = disp_shift;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        tvalid_d = (state_d == S_ACTIVE);
        tuser_d  = tvalid_d && (bx_d == '0) && (y_d == '0);
        tlast_d  = tvalid_d && (bx_d == BX_LAST);
        tdata_d  = tvalid_d ? beat_pixels(bx_d, y_d, d_d) : '0;
    end

    // State and output registers; reset clears tvalid immediately.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            bx_q     <= '0;
            y_q      <= '0;
            gap_q    <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            y_q      <= y_d;
            gap_q    <= gap_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_axis_img_tdata  = tdata_q;
    assign m_axis_img_tuser  = tuser_q;
    assign m_axis_img_tlast  = tlast_q;
    assign m_axis_img_tvalid = tvalid_q;
    assign frame_cnt         = cnt_q;
    assign frame_done        = accept & tlast_q & (y_q == Y_LAST);

endmodule
